// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package regfile_wb_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 64;

  localparam logic [DATA_W-1:0]     zero_word = '0;
  localparam logic [REG_ADDR_W-1:0] reg_x0    = '0;

  // Which requester wins the next tie (both A and B valid).
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } rr_prio_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. req[0]/gnt[0] is requester A, req[1]/gnt[1]
// is requester B. The priority pointer only moves when both requested, so a
// lone requester never disturbs the tie order.
module rr_arbiter2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_prio_e prio_q, prio_d;

  // Grant selection and pointer advance on contention.
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (prio_q == PRIO_A) begin
          gnt    = 2'b01;
          prio_d = PRIO_B;
        end else begin
          gnt    = 2'b10;
          prio_d = PRIO_A;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  // Priority pointer register; A wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= PRIO_A;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard for the integer register file.
// Handshakes: a requester transfers in a cycle where valid && ready; ready is a
// combinational grant, and requesters hold rd/data stable while valid && !ready.
// issue_ready is combinational and does not depend on issue_valid.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_wr,
  input  logic                  flush,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_rd,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_rd_q, wr_rd_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            gnt;
  logic                  haz;
  logic                  issue_fire;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // Hazard detection; busy_q[0] is always 0 so x0 never stalls.
  always_comb begin
    haz         = busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_wr & busy_q[issue_rd]);
    issue_ready = ~flush & ~haz;
    issue_fire  = issue_valid & issue_ready & issue_wr & (issue_rd != reg_x0);
  end

  // Capture the granted write-back; an x0 write is consumed without a write.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (gnt[0]) begin
      wr_en_d   = (a_rd != reg_x0);
      wr_rd_d   = a_rd;
      wr_data_d = a_data;
    end else if (gnt[1]) begin
      wr_en_d   = (b_rd != reg_x0);
      wr_rd_d   = b_rd;
      wr_data_d = b_data;
    end
  end

  // Scoreboard next state: clear on write, set on issue (set wins), flush wipes all.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)    busy_d[wr_rd_q]  = 1'b0;
    if (issue_fire) busy_d[issue_rd] = 1'b1;
    if (flush)      busy_d           = '0;
    busy_d[0] = 1'b0;
  end

  // Write-back output register and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= reg_x0;
      wr_data_q <= DATA_WIDTH'(zero_word);
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed scenarios followed by a
// randomized phase, all checked against a behavioural model of the scheduler.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_wr, flush;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [63:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [63:0] wr_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_busy;
  bit          m_prio_b;      // 1: B wins the next tie
  bit          m_cur_en;      // model says a write is on the port this cycle
  logic [4:0]  m_cur_rd;
  logic [68:0] exp_q[$];      // expected register-file writes {rd, data}
  bit          acc_a, acc_b;  // model's view of last cycle's acceptances

  regfile_wb_scheduler #(.DATA_WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_wr    (issue_wr),
    .flush       (flush),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = '0;
    m_prio_b = 1'b0;
    m_cur_en = 1'b0;
    m_cur_rd = '0;
    acc_a    = 1'b0;
    acc_b    = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wr = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    flush = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  // One clock cycle: inputs are already driven (posedge+1). Check combinational
  // outputs mid-cycle, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    logic        haz, e_ir, e_ar, e_br;
    logic [31:0] nb;
    logic [68:0] item;
    #2;
    haz  = m_busy[issue_rs1] | m_busy[issue_rs2] | (issue_wr & m_busy[issue_rd]);
    e_ir = !flush && !haz;
    e_ar = a_valid && (!b_valid || !m_prio_b);
    e_br = b_valid && (!a_valid || m_prio_b);
    chk("issue_ready", issue_ready, e_ir);
    chk("a_ready", a_ready, e_ar);
    chk("b_ready", b_ready, e_br);
    acc_a = e_ar;
    acc_b = e_br;
    nb = m_busy;
    if (m_cur_en) nb[m_cur_rd] = 1'b0;
    if (issue_valid && e_ir && issue_wr && issue_rd != 0) nb[issue_rd] = 1'b1;
    if (flush) nb = '0;
    if (a_valid && b_valid) m_prio_b = !m_prio_b;
    if (e_ar && a_rd != 0) exp_q.push_back({a_rd, a_data});
    if (e_br && b_rd != 0) exp_q.push_back({b_rd, b_data});
    @(posedge clk);
    #1;
    m_busy = nb;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      m_cur_en = 1'b1;
      m_cur_rd = item[68:64];
      chk("wr_en", wr_en, 1);
      chk("wr_rd", wr_rd, item[68:64]);
      chk("wr_data", wr_data, item[63:0]);
    end else begin
      m_cur_en = 1'b0;
      chk("wr_en", wr_en, 0);
    end
    chk("busy", busy, m_busy);
  endtask

  task automatic do_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr);
    issue_valid = 1'b1;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_wr = wr;
  endtask

  initial begin
    // Reset block.
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_rd", wr_rd, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    // Contention: both requesters valid for 4 cycles -> A,B,A,B.
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'hA0;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 64'hB0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      a_data = a_data + 1;
      b_data = b_data + 1;
    end
    idle();
    cycle();

    // RAW stall on x5 and release after the write-back.
    do_issue(5'd0, 5'd0, 5'd5, 1'b1);
    cycle();
    do_issue(5'd5, 5'd0, 5'd6, 1'b1);
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
    cycle();
    a_valid = 1'b0;
    cycle();
    cycle();
    idle();

    // x0 destination: issue leaves busy alone, write is consumed silently.
    do_issue(5'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    idle();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 64'h55;
    cycle();
    idle();
    cycle();

    // Retire x6, then build busy = 0x000000F0.
    a_valid = 1'b1; a_rd = 5'd6; a_data = 64'h66;
    cycle();
    idle();
    cycle();
    for (int r = 4; r < 8; r++) begin
      do_issue(5'd0, 5'd0, 5'(r), 1'b1);
      cycle();
    end
    idle();
    chk("busy_f0", busy, 32'h0000_00F0);

    // Flush with a write-back in flight; then same-edge set/clear on x7.
    flush = 1'b1;
    do_issue(5'd0, 5'd0, 5'd8, 1'b1);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 64'h77;
    cycle();
    idle();
    do_issue(5'd0, 5'd0, 5'd7, 1'b1);
    a_valid = 1'b1; a_rd = 5'd4; a_data = 64'h44;
    cycle();
    idle();
    cycle();
    chk("busy_x7_set_wins", busy, 32'h0000_0080);

    // Asynchronous reset mid-cycle with state pending.
    do_issue(5'd0, 5'd0, 5'd9, 1'b1);
    a_valid = 1'b1; a_rd = 5'd10; a_data = 64'hDEAD;
    cycle();
    idle();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_valid = 1'b1; a_rd = 5'd11; a_data = 64'h1111;
    b_valid = 1'b1; b_rd = 5'd12; b_data = 64'h2222;
    cycle();
    b_valid = 1'b0;
    a_valid = 1'b0;
    cycle();

    // Randomized phase.
    idle();
    acc_a = 1'b1;
    acc_b = 1'b1;
    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_wr    = 1'($urandom_range(0, 1));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      issue_rd    = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 24) == 0);
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd    = 5'($urandom_range(0, 7));
        a_data  = {$urandom(), $urandom()};
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd    = 5'($urandom_range(0, 7));
        b_data  = {$urandom(), $urandom()};
      end
      cycle();
    end
    idle();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
